uart_frame_bridge: RTL and testbench

Parametrised byte-to-frame bridge between the UART receiver/transmitter and the bitonic sorter. It collects a stream of received bytes into one wide frame of `NUM_ELEMS` elements of `ELEM_W` bits and offers it to the sorter with a valid/ready handshake. It accepts the sorted result frame and serialises it back out, byte by byte, through the UART transmitter. It replaces the single-direction receive buffer and adds idle-timeout resynchronisation and overrun reporting.

---
 rtl/uart_frame_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_frame_bridge.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_frame_bridge
// Brief    : Collects UART bytes into a sorter frame and serialises the sorted
//            result frame back out through the UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_bridge #(
    parameter int NUM_ELEMS      = 8,
    parameter int ELEM_W         = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_byte,
    output logic [NUM_ELEMS*ELEM_W-1:0] frame_data,
    output logic                        frame_valid,
    input  logic                        frame_ready,
    input  logic [NUM_ELEMS*ELEM_W-1:0] result_data,
    input  logic                        result_valid,
    output logic                        result_ready,
    output logic [7:0]                  tx_byte,
    output logic                        tx_start,
    input  logic                        tx_busy,
    output logic                        rx_overrun,
    output logic                        timeout_flush
);

    localparam int c_BPE         = ELEM_W / 8;
    localparam int c_FRAME_BYTES = NUM_ELEMS * c_BPE;
    localparam int c_CNT_W       = $clog2(c_FRAME_BYTES);
    localparam int c_TO_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit c_TO_EN       = (TIMEOUT_CYCLES != 0);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_FRAME_BYTES - 1);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [0:0] c_RX_COLLECT = 1'b0;
    localparam logic [0:0] c_RX_HOLD    = 1'b1;

    localparam logic [1:0] c_TX_IDLE  = 2'd0;
    localparam logic [1:0] c_TX_START = 2'd1;
    localparam logic [1:0] c_TX_WAIT  = 2'd2;

    // ------------------------------------------------------------------ RX
    logic [0:0]         r_rx_state, w_rx_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [c_TO_W-1:0]  r_idle, w_idle_nxt;
    logic [7:0]         r_bytes [c_FRAME_BYTES];
    logic               r_frame_valid;
    logic               r_overrun;
    logic               r_flush;
    logic               w_wr_en;
    logic [c_CNT_W-1:0] w_wr_idx;
    logic               w_flush;
    logic               w_overrun;

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_cnt_nxt      = r_cnt;
        w_idle_nxt     = r_idle;
        w_wr_en        = 1'b0;
        w_wr_idx       = r_cnt;
        w_flush        = 1'b0;
        w_overrun      = 1'b0;
        case (r_rx_state)
            c_RX_COLLECT: begin
                if (rx_valid) begin
                    w_wr_en    = 1'b1;
                    w_idle_nxt = '0;
                    if (r_cnt == c_CNT_LAST) begin
                        w_cnt_nxt      = '0;
                        w_rx_state_nxt = c_RX_HOLD;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else if (c_TO_EN && (r_cnt != '0)) begin
                    // This cycle is the TIMEOUT_CYCLES-th idle one: flush now
                    if (r_idle == c_TO_LAST) begin
                        w_flush    = 1'b1;
                        w_cnt_nxt  = '0;
                        w_idle_nxt = '0;
                    end else begin
                        w_idle_nxt = r_idle + 1'b1;
                    end
                end
            end
            c_RX_HOLD: begin
                if (frame_ready) begin
                    w_rx_state_nxt = c_RX_COLLECT;
                    w_idle_nxt     = '0;
                    if (rx_valid) begin
                        w_wr_en   = 1'b1;
                        w_wr_idx  = '0;
                        w_cnt_nxt = c_CNT_W'(1);
                    end
                end else if (rx_valid) begin
                    w_overrun = 1'b1;
                end
            end
            default: w_rx_state_nxt = c_RX_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state    <= c_RX_COLLECT;
            r_cnt         <= '0;
            r_idle        <= '0;
            r_frame_valid <= 1'b0;
            r_overrun     <= 1'b0;
            r_flush       <= 1'b0;
            for (int i = 0; i < c_FRAME_BYTES; i++) r_bytes[i] <= '0;
        end else begin
            r_rx_state    <= w_rx_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idle        <= w_idle_nxt;
            r_frame_valid <= (w_rx_state_nxt == c_RX_HOLD);
            r_overrun     <= w_overrun;
            r_flush       <= w_flush;
            if (w_flush) begin
                for (int i = 0; i < c_FRAME_BYTES; i++) r_bytes[i] <= '0;
            end else if (w_wr_en) begin
                r_bytes[w_wr_idx] <= rx_byte;
            end
        end
    end

    for (genvar gi = 0; gi < c_FRAME_BYTES; gi++) begin : g_pack
        assign frame_data[gi*8 +: 8] = r_bytes[gi];
    end

    assign frame_valid   = r_frame_valid;
    assign rx_overrun    = r_overrun;
    assign timeout_flush = r_flush;

    // ------------------------------------------------------------------ TX
    logic [1:0]         r_tx_state, w_tx_state_nxt;
    logic [c_CNT_W-1:0] r_idx, w_idx_nxt;
    logic [7:0]         r_res [c_FRAME_BYTES];
    logic               r_wait_min, w_wait_min_nxt;
    logic               r_tx_start;
    logic [7:0]         r_tx_byte;
    logic               w_capture;
    logic               w_start;
    logic [7:0]         w_start_byte;
    logic [7:0]         w_cur_byte;

    assign w_cur_byte = r_res[r_idx];

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_idx_nxt      = r_idx;
        w_wait_min_nxt = r_wait_min;
        w_capture      = 1'b0;
        w_start        = 1'b0;
        w_start_byte   = r_tx_byte;
        case (r_tx_state)
            c_TX_IDLE: begin
                if (result_valid) begin
                    w_capture = 1'b1;
                    w_idx_nxt = '0;
                    // Issue byte 0 straight from the handshake so tx_start follows by one cycle
                    if (!tx_busy) begin
                        w_start        = 1'b1;
                        w_start_byte   = result_data[7:0];
                        w_wait_min_nxt = 1'b0;
                        w_tx_state_nxt = c_TX_WAIT;
                    end else begin
                        w_tx_state_nxt = c_TX_START;
                    end
                end
            end
            c_TX_START: begin
                if (!tx_busy) begin
                    w_start        = 1'b1;
                    w_start_byte   = w_cur_byte;
                    w_wait_min_nxt = 1'b0;
                    w_tx_state_nxt = c_TX_WAIT;
                end
            end
            c_TX_WAIT: begin
                if (!r_wait_min) begin
                    w_wait_min_nxt = 1'b1;
                end else if (!tx_busy) begin
                    if (r_idx == c_CNT_LAST) begin
                        w_tx_state_nxt = c_TX_IDLE;
                    end else begin
                        w_idx_nxt      = r_idx + 1'b1;
                        w_tx_state_nxt = c_TX_START;
                    end
                end
            end
            default: w_tx_state_nxt = c_TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= c_TX_IDLE;
            r_idx      <= '0;
            r_wait_min <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_byte  <= '0;
            for (int i = 0; i < c_FRAME_BYTES; i++) r_res[i] <= '0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_idx      <= w_idx_nxt;
            r_wait_min <= w_wait_min_nxt;
            r_tx_start <= w_start;
            if (w_start) r_tx_byte <= w_start_byte;
            if (w_capture) begin
                for (int i = 0; i < c_FRAME_BYTES; i++) r_res[i] <= result_data[i*8 +: 8];
            end
        end
    end

    assign tx_start     = r_tx_start;
    assign tx_byte      = r_tx_byte;
    assign result_ready = (r_tx_state == c_TX_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_bridge
// Brief    : Randomised self-checking bench for uart_frame_bridge against a
//            byte-array / queue reference model and a busy-for-20 transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_bridge;

    localparam int NE = 8;
    localparam int EW = 16;
    localparam int TO = 50;
    localparam int FB = NE * EW / 8;
    localparam int FW = NE * EW;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_byte;
    logic [FW-1:0] frame_data;
    logic          frame_valid;
    logic          frame_ready;
    logic [FW-1:0] result_data;
    logic          result_valid;
    logic          result_ready;
    logic [7:0]    tx_byte;
    logic          tx_start;
    logic          tx_busy;
    logic          rx_overrun;
    logic          timeout_flush;

    uart_frame_bridge #(.NUM_ELEMS(NE), .ELEM_W(EW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .result_data(result_data), .result_valid(result_valid), .result_ready(result_ready),
        .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_overrun(rx_overrun), .timeout_flush(timeout_flush)
    );

    always #5 clk = ~clk;

    // Transmitter: busy for 20 cycles, starting the cycle after tx_start
    int busy_left = 0;
    always @(posedge clk) begin
        if (tx_start) busy_left <= 20;
        else if (busy_left > 0) busy_left <= busy_left - 1;
    end
    assign tx_busy = (busy_left != 0);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------------------------------------------------- reference model
    logic [7:0] m_bytes [FB];
    int         m_cnt, m_idle;
    bit         m_hold, m_ov, m_fl;
    logic [7:0] m_q [$];
    bit         m_ready, m_first_due;
    int         m_age;

    function automatic logic [FW-1:0] m_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < FB; i++) f[i*8 +: 8] = m_bytes[i];
        return f;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FB; i++) m_bytes[i] = 8'h00;
            m_cnt = 0; m_idle = 0; m_hold = 0; m_ov = 0; m_fl = 0;
            m_q.delete(); m_ready = 1; m_first_due = 0; m_age = 0;
        end else begin
            m_ov = 0;
            m_fl = 0;
            if (m_hold) begin
                if (frame_ready) begin
                    m_hold = 0; m_cnt = 0; m_idle = 0;
                    if (rx_valid) begin m_bytes[0] = rx_byte; m_cnt = 1; end
                end else if (rx_valid) begin
                    m_ov = 1;
                end
            end else if (rx_valid) begin
                m_bytes[m_cnt] = rx_byte;
                m_idle = 0;
                if (m_cnt == FB - 1) begin m_hold = 1; m_cnt = 0; end
                else m_cnt++;
            end else if (m_cnt > 0) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_fl = 1; m_cnt = 0; m_idle = 0;
                    for (int i = 0; i < FB; i++) m_bytes[i] = 8'h00;
                end
            end

            m_first_due = 0;
            if (m_ready) begin
                if (result_valid) begin
                    for (int i = 0; i < FB; i++) m_q.push_back(result_data[i*8 +: 8]);
                    m_ready = 0;
                    m_first_due = !tx_busy;
                    m_age = 0;
                end
            end else if (m_q.size() == 0 && m_age >= 1 && !tx_busy) begin
                m_ready = 1;
            end else begin
                m_age++;
            end
        end
    end

    // ---------------------------------------------------------- compare process
    int         ovr_seen = 0;
    logic [7:0] tx_log [$];

    always @(negedge clk) begin
        if (rst) begin
            chk("frame_valid", {127'd0, frame_valid}, {127'd0, m_hold});
            chk("frame_data", frame_data, m_frame());
            chk("rx_overrun", {127'd0, rx_overrun}, {127'd0, m_ov});
            chk("timeout_flush", {127'd0, timeout_flush}, {127'd0, m_fl});
            chk("result_ready", {127'd0, result_ready}, {127'd0, m_ready});
            if (m_first_due) chk("tx_start_latency", {127'd0, tx_start}, 1);
            if (tx_start) begin
                chk("tx_start_while_busy", {127'd0, tx_busy}, 0);
                if (m_q.size() == 0) begin
                    chk("tx_spurious_start", {127'd0, tx_start}, 0);
                end else begin
                    chk("tx_byte", {120'd0, tx_byte}, {120'd0, m_q.pop_front()});
                    m_age = 0;
                end
                tx_log.push_back(tx_byte);
            end
            if (rx_overrun) ovr_seen++;
        end
    end

    // ---------------------------------------------------------- stimulus
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx_done(input string nm);
        int k = 0;
        while (!result_ready && k < 2000) begin @(negedge clk); k++; end
        chk(nm, {127'd0, result_ready}, 1);
    endtask

    task automatic rx_random(input int nbytes, input bit long_gaps);
        for (int b = 0; b < nbytes; b++) begin
            int gap;
            if (long_gaps && $urandom_range(0, 19) == 0) gap = $urandom_range(45, 60);
            else gap = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) begin
                frame_ready = ($urandom_range(0, 2) == 0);
                @(negedge clk);
            end
            frame_ready = ($urandom_range(0, 2) == 0);
            send_byte(8'($urandom));
        end
        frame_ready = 1'b1;
        repeat (2) @(negedge clk);
        frame_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int ov0;
        rst = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; frame_ready = 1'b0;
        result_valid = 1'b0; result_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_frame_valid", {127'd0, frame_valid}, 0);
        chk("rst_frame_data", frame_data, 0);
        chk("rst_tx_start", {127'd0, tx_start}, 0);
        chk("rst_tx_byte", {120'd0, tx_byte}, 0);
        chk("rst_overrun", {127'd0, rx_overrun}, 0);
        chk("rst_flush", {127'd0, timeout_flush}, 0);
        chk("rst_result_ready", {127'd0, result_ready}, 1);
        rst = 1'b1;
        @(negedge clk);

        // Frame assembly 0x01..0x10
        for (int i = 1; i <= 16; i++) send_byte(8'(i));
        chk("asm_valid", {127'd0, frame_valid}, 1);
        chk("asm_elem0", {112'd0, frame_data[15:0]}, 16'h0201);
        chk("asm_elem7", {112'd0, frame_data[127:112]}, 16'h100F);

        // Overrun while held
        ov0 = ovr_seen;
        send_byte(8'h55);
        send_byte(8'h66);
        @(negedge clk);
        chk("overrun_count", ovr_seen - ov0, 2);
        chk("overrun_data", {112'd0, frame_data[15:0]}, 16'h0201);
        frame_ready = 1'b1; rx_valid = 1'b1; rx_byte = 8'hAA;
        @(negedge clk);
        frame_ready = 1'b0; rx_valid = 1'b0;
        chk("hs_valid_low", {127'd0, frame_valid}, 0);
        chk("hs_byte0", {120'd0, frame_data[7:0]}, 8'hAA);
        for (int i = 1; i < 16; i++) send_byte(8'(8'h10 + i));
        chk("hs_frame_valid", {127'd0, frame_valid}, 1);
        chk("hs_frame_lo", {112'd0, frame_data[15:0]}, 16'h11AA);
        frame_ready = 1'b1; @(negedge clk); frame_ready = 1'b0;

        // Timeout: 50 idle cycles, pulse appears in the following cycle
        for (int i = 0; i < 5; i++) send_byte(8'(8'hB0 + i));
        k = 1;
        while (!timeout_flush && k < 200) begin @(negedge clk); k++; end
        chk("timeout_latency", k, TO + 1);
        chk("timeout_data", frame_data, 0);
        for (int i = 0; i < 16; i++) send_byte(8'(8'hC0 + i));
        chk("post_to_valid", {127'd0, frame_valid}, 1);
        chk("post_to_lo", {112'd0, frame_data[15:0]}, 16'hC1C0);
        frame_ready = 1'b1; @(negedge clk); frame_ready = 1'b0;

        // TX serialisation concurrent with RX
        for (int i = 0; i < FB; i++) result_data[i*8 +: 8] = 8'(i);
        tx_log.delete();
        result_valid = 1'b1; @(negedge clk); result_valid = 1'b0;
        chk("tx_first_start", {127'd0, tx_start}, 1);
        chk("tx_first_byte", {120'd0, tx_byte}, 0);
        chk("tx_ready_low", {127'd0, result_ready}, 0);
        fork
            wait_tx_done("tx_done");
            rx_random(32, 1'b0);
        join
        chk("tx_count", tx_log.size(), 16);
        for (int i = 0; i < 16 && i < tx_log.size(); i++) chk("tx_order", {120'd0, tx_log[i]}, i);

        // Randomised concurrent traffic
        fork
            rx_random(600, 1'b1);
            begin
                for (int f = 0; f < 6; f++) begin
                    wait_tx_done("rand_tx_ready");
                    repeat ($urandom_range(0, 10)) @(negedge clk);
                    result_data = {$urandom, $urandom, $urandom, $urandom};
                    result_valid = 1'b1;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    result_valid = 1'b0;
                end
                wait_tx_done("rand_tx_last");
            end
        join

        // Reset in the middle of RX and TX
        for (int i = 0; i < FB; i++) result_data[i*8 +: 8] = 8'(8'h80 + i);
        result_valid = 1'b1; @(negedge clk); result_valid = 1'b0;
        for (int i = 0; i < 7; i++) send_byte(8'(8'h30 + i));
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_frame_valid", {127'd0, frame_valid}, 0);
        chk("mid_rst_frame_data", frame_data, 0);
        chk("mid_rst_tx_start", {127'd0, tx_start}, 0);
        chk("mid_rst_tx_byte", {120'd0, tx_byte}, 0);
        chk("mid_rst_overrun", {127'd0, rx_overrun}, 0);
        chk("mid_rst_flush", {127'd0, timeout_flush}, 0);
        chk("mid_rst_ready", {127'd0, result_ready}, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++) send_byte(8'(8'h40 + i));
        chk("rec_valid", {127'd0, frame_valid}, 1);
        chk("rec_lo", {112'd0, frame_data[15:0]}, 16'h4140);
        frame_ready = 1'b1; @(negedge clk); frame_ready = 1'b0;
        for (int i = 0; i < FB; i++) result_data[i*8 +: 8] = 8'(8'hA0 + i);
        tx_log.delete();
        result_valid = 1'b1; @(negedge clk); result_valid = 1'b0;
        wait_tx_done("rec_tx_done");
        chk("rec_tx_count", tx_log.size(), 16);
        if (tx_log.size() == 16) chk("rec_tx_last", {120'd0, tx_log[15]}, 8'hAF);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
